bin_to_bcd_serial: RTL

//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bin_to_bcd_serial_if.sv | 16 +
 rtl/bcd_digit_adj.sv | 9 +
 rtl/bin_to_bcd_serial.sv | 97 +++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int                    BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD    = 4'd3;
endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Valid/ready bus between a binary producer, the converter and the BCD consumer.
interface bin_to_bcd_serial_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  i_valid;
    logic                  o_ready;
    logic [BIN_W-1:0]      i_bin;
    logic                  o_valid;
    logic                  i_ready;
    logic [4*DIGITS-1:0]   o_bcd;
    logic                  o_overflow;

    modport master (output i_valid, i_bin, i_ready, input o_ready, o_valid, o_bcd, o_overflow);
    modport slave  (input i_valid, i_bin, i_ready, output o_ready, o_valid, o_bcd, o_overflow);
endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a digit that is 5 or more, zero latency.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din_i,
    output logic [BCD_DIGIT_W-1:0] dout_o
);
    assign dout_o = (din_i >= ADJ_THRESH) ? din_i + ADJ_ADD : din_i;
endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD (double dabble, one bit/clock); result valid BIN_W+1 cycles after accept.
// Result held until the consumer takes it; a new value may be loaded on that same edge.
module bin_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    bin_to_bcd_serial_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = BCD_W + BIN_W;

    if (DIGITS < 1 || BIN_W < 1) begin : g_bad_params
        $error("bin_to_bcd_serial: DIGITS and BIN_W must both be >= 1");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [ACC_W-1:0]   acc;
    logic               rdy;
    logic               take;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din_i  (bcd_q[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout_o (bcd_adj[k*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign rdy  = (state_q == IDLE) | ((state_q == DONE) & bus.i_ready);
    assign take = bus.i_valid & rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        acc     = '0;
        case (state_q)
            IDLE: ;
            SHIFT: begin
                // Digits never exceed 9 before the shift, so per-digit adjust cannot carry.
                acc     = {bcd_adj, shift_q} << 1;
                bcd_d   = acc[ACC_W-1 -: BCD_W];
                shift_d = acc[BIN_W-1:0];
                ovf_d   = ovf_q | bcd_adj[BCD_W-1];
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d = SHIFT;
            shift_d = bus.i_bin;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CNT_W'(BIN_W);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_ready    = rdy;
    assign bus.o_valid    = (state_q == DONE);
    assign bus.o_bcd      = bcd_q;
    assign bus.o_overflow = ovf_q;
endmodule
